// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one data RAM between the pipeline MEM stage (A) and a loader/debug port (B).
// Define MEM_ARB_FIXED_PRIO_EN to make port A win every simultaneous request instead of round-robin.
module mem_arbiter #(
  parameter int ACC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        CLR,
  input  logic        a_req,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  input  logic        a_we,
  input  logic        a_byte,
  input  logic        a_half,
  input  logic        a_uext,
  output logic        a_ack,
  output logic [31:0] a_rdata,
  output logic        a_err,
  output logic        a_stall,
  input  logic        b_req,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  input  logic        b_we,
  input  logic        b_byte,
  input  logic        b_half,
  input  logic        b_uext,
  output logic        b_ack,
  output logic [31:0] b_rdata,
  output logic        b_err,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_din,
  output logic        ram_we,
  output logic        ram_byte,
  output logic        ram_half,
  output logic        ram_uext,
  input  logic [31:0] ram_dout
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_e;
  localparam logic [1:0] CNT_INIT = 2'(ACC_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        byte_q, byte_d;
  logic        half_q, half_d;
  logic        uext_q, uext_d;
  logic        err_q, err_d;
  logic        winner_s;

  // byte wins over half; a word needs both low address bits clear, a half needs bit 0 clear
  function automatic logic misaligned(input logic [1:0] lsb, input logic sz_byte, input logic sz_half);
    logic word_s;
    word_s     = ~sz_byte & ~sz_half;
    misaligned = (sz_half & ~sz_byte & lsb[0]) | (word_s & (lsb != 2'b00));
  endfunction

  always_ff @(posedge clk) begin
    if (CLR) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      last_grant_q <= 1'b1;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      we_q         <= 1'b0;
      byte_q       <= 1'b0;
      half_q       <= 1'b0;
      uext_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      byte_q       <= byte_d;
      half_q       <= half_d;
      uext_q       <= uext_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    byte_d       = byte_q;
    half_d       = half_q;
    uext_d       = uext_q;
    err_d        = err_q;
    winner_s     = last_grant_q;
    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          if (a_req && b_req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            winner_s = 1'b0;
`else
            winner_s = ~last_grant_q;
`endif
          end else begin
            winner_s = b_req;
          end
          state_d      = BUSY;
          cnt_d        = CNT_INIT;
          last_grant_d = winner_s;
          if (winner_s) begin
            addr_d  = b_addr;
            wdata_d = b_wdata;
            we_d    = b_we;
            byte_d  = b_byte;
            half_d  = b_half & ~b_byte;
            uext_d  = b_uext;
            err_d   = misaligned(b_addr[1:0], b_byte, b_half);
          end else begin
            addr_d  = a_addr;
            wdata_d = a_wdata;
            we_d    = a_we;
            byte_d  = a_byte;
            half_d  = a_half & ~a_byte;
            uext_d  = a_uext;
            err_d   = misaligned(a_addr[1:0], a_byte, a_half);
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // completion is suppressed while CLR is high so an aborted access never writes or acks
  always_comb begin
    ram_addr = 32'd0;
    ram_din  = 32'd0;
    ram_we   = 1'b0;
    ram_byte = 1'b0;
    ram_half = 1'b0;
    ram_uext = 1'b0;
    a_ack    = 1'b0;
    a_err    = 1'b0;
    a_rdata  = 32'd0;
    b_ack    = 1'b0;
    b_err    = 1'b0;
    b_rdata  = 32'd0;
    if (state_q == BUSY) begin
      ram_addr = addr_q;
      ram_din  = wdata_q;
      ram_byte = byte_q;
      ram_half = half_q;
      ram_uext = uext_q;
      if ((cnt_q == 2'd0) && !CLR) begin
        ram_we = we_q & ~err_q;
        if (last_grant_q) begin
          b_ack   = 1'b1;
          b_err   = err_q;
          b_rdata = (we_q || err_q) ? 32'd0 : ram_dout;
        end else begin
          a_ack   = 1'b1;
          a_err   = err_q;
          a_rdata = (we_q || err_q) ? 32'd0 : ram_dout;
        end
      end else begin
        ram_we = 1'b0;
      end
    end else begin
      ram_we = 1'b0;
    end
  end

  assign a_stall = a_req & ~a_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with ACC_CYCLES=1 and one with ACC_CYCLES=3,
// each backed by a small word RAM model, sharing the same requester stimulus.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        CLR;
  logic        a_req, a_we, a_byte, a_half, a_uext;
  logic [31:0] a_addr, a_wdata;
  logic        b_req, b_we, b_byte, b_half, b_uext;
  logic [31:0] b_addr, b_wdata;

  logic        a_ack1, a_err1, a_stall1, b_ack1, b_err1;
  logic [31:0] a_rdata1, b_rdata1, ram_addr1, ram_din1, ram_dout1;
  logic        ram_we1, ram_byte1, ram_half1, ram_uext1;
  logic        a_ack3, a_err3, a_stall3, b_ack3, b_err3;
  logic [31:0] a_rdata3, b_rdata3, ram_addr3, ram_din3, ram_dout3;
  logic        ram_we3, ram_byte3, ram_half3, ram_uext3;

  int checks = 0;
  int passes = 0;

  mem_arbiter #(.ACC_CYCLES(1)) dut1 (
    .clk(clk), .CLR(CLR),
    .a_req(a_req), .a_addr(a_addr), .a_wdata(a_wdata), .a_we(a_we),
    .a_byte(a_byte), .a_half(a_half), .a_uext(a_uext),
    .a_ack(a_ack1), .a_rdata(a_rdata1), .a_err(a_err1), .a_stall(a_stall1),
    .b_req(b_req), .b_addr(b_addr), .b_wdata(b_wdata), .b_we(b_we),
    .b_byte(b_byte), .b_half(b_half), .b_uext(b_uext),
    .b_ack(b_ack1), .b_rdata(b_rdata1), .b_err(b_err1),
    .ram_addr(ram_addr1), .ram_din(ram_din1), .ram_we(ram_we1),
    .ram_byte(ram_byte1), .ram_half(ram_half1), .ram_uext(ram_uext1),
    .ram_dout(ram_dout1)
  );

  mem_arbiter #(.ACC_CYCLES(3)) dut3 (
    .clk(clk), .CLR(CLR),
    .a_req(a_req), .a_addr(a_addr), .a_wdata(a_wdata), .a_we(a_we),
    .a_byte(a_byte), .a_half(a_half), .a_uext(a_uext),
    .a_ack(a_ack3), .a_rdata(a_rdata3), .a_err(a_err3), .a_stall(a_stall3),
    .b_req(b_req), .b_addr(b_addr), .b_wdata(b_wdata), .b_we(b_we),
    .b_byte(b_byte), .b_half(b_half), .b_uext(b_uext),
    .b_ack(b_ack3), .b_rdata(b_rdata3), .b_err(b_err3),
    .ram_addr(ram_addr3), .ram_din(ram_din3), .ram_we(ram_we3),
    .ram_byte(ram_byte3), .ram_half(ram_half3), .ram_uext(ram_uext3),
    .ram_dout(ram_dout3)
  );

  // word RAM models, preloaded with 0xA000_0000 + word index
  logic        init_mem;
  logic [31:0] mem1 [16];
  logic [31:0] mem3 [16];

  always @(posedge clk) begin
    for (int i = 0; i < 16; i++) begin
      if (init_mem) begin
        mem1[i] <= 32'hA000_0000 + 32'(i);
        mem3[i] <= 32'hA000_0000 + 32'(i);
      end
    end
    if (!init_mem && ram_we1) mem1[ram_addr1[5:2]] <= ram_din1;
    if (!init_mem && ram_we3) mem3[ram_addr3[5:2]] <= ram_din3;
  end

  assign ram_dout1 = mem1[ram_addr1[5:2]];
  assign ram_dout3 = mem3[ram_addr3[5:2]];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_req = 1'b0; a_we = 1'b0; a_byte = 1'b0; a_half = 1'b0; a_uext = 1'b0;
    a_addr = 32'd0; a_wdata = 32'd0;
    b_req = 1'b0; b_we = 1'b0; b_byte = 1'b0; b_half = 1'b0; b_uext = 1'b0;
    b_addr = 32'd0; b_wdata = 32'd0;
    CLR = 1'b1;
    next_cycle();
    CLR = 1'b0;
  endtask

  task automatic test_reset();
    logic [136:0] o1, o3;
    do_reset();
    @(negedge clk);
    o1 = {ram_we1, ram_byte1, ram_half1, ram_uext1, ram_addr1, ram_din1, a_ack1, a_err1, a_rdata1, a_stall1, b_ack1, b_err1, b_rdata1};
    o3 = {ram_we3, ram_byte3, ram_half3, ram_uext3, ram_addr3, ram_din3, a_ack3, a_err3, a_rdata3, a_stall3, b_ack3, b_err3, b_rdata3};
    checks++;
    if (|o1 !== 1'b0) $display("FAIL reset_outputs_acc1 got=%h want=0", o1);
    else passes++;
    checks++;
    if (|o3 !== 1'b0) $display("FAIL reset_outputs_acc3 got=%h want=0", o3);
    else passes++;
  endtask

  task automatic test_write_read();
    do_reset();
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'h10; a_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if ({a_ack1, a_stall1, ram_we1} !== 3'b010) $display("FAIL wr_idle ack/stall/we got=%b want=010", {a_ack1, a_stall1, ram_we1});
    else passes++;
    next_cycle(); @(negedge clk);
    checks++;
    if ({a_ack1, a_err1, ram_we1, a_stall1} !== 4'b1010) $display("FAIL wr_done ack/err/we/stall got=%b want=1010", {a_ack1, a_err1, ram_we1, a_stall1});
    else passes++;
    checks++;
    if ({ram_addr1, ram_din1, a_rdata1} !== {32'h10, 32'hDEAD_BEEF, 32'd0}) $display("FAIL wr_bus addr/din/rdata got=%h %h %h want=10 deadbeef 0", ram_addr1, ram_din1, a_rdata1);
    else passes++;
    next_cycle();
    a_we = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_ack1, ram_we1, ram_addr1} !== {2'b00, 32'd0}) $display("FAIL rd_idle ack/we/addr got=%b %b %h want=0 0 0", a_ack1, ram_we1, ram_addr1);
    else passes++;
    next_cycle(); @(negedge clk);
    checks++;
    if ({a_ack1, ram_we1, a_rdata1} !== {2'b10, 32'hDEAD_BEEF}) $display("FAIL rd_done ack/we/rdata got=%b %b %h want=1 0 deadbeef", a_ack1, ram_we1, a_rdata1);
    else passes++;
    next_cycle();
    a_req = 1'b0;
  endtask

  task automatic test_sizes();
    do_reset();
    a_req = 1'b1; a_we = 1'b0; a_byte = 1'b1; a_half = 1'b1; a_uext = 1'b1; a_addr = 32'h13;
    next_cycle(); @(negedge clk);
    checks++;
    if ({a_ack1, a_err1, ram_byte1, ram_half1, ram_uext1, a_rdata1} !== {5'b10101, 32'hDEAD_BEEF}) $display("FAIL size_byte ack/err/byte/half/uext/rdata got=%b %h want=10101 deadbeef", {a_ack1, a_err1, ram_byte1, ram_half1, ram_uext1}, a_rdata1);
    else passes++;
    next_cycle();
    a_byte = 1'b0; a_half = 1'b1; a_uext = 1'b0; a_addr = 32'h12;
    next_cycle(); @(negedge clk);
    checks++;
    if ({a_ack1, a_err1, ram_byte1, ram_half1, ram_uext1} !== 5'b10010) $display("FAIL size_half ack/err/byte/half/uext got=%b want=10010", {a_ack1, a_err1, ram_byte1, ram_half1, ram_uext1});
    else passes++;
    next_cycle();
    a_half = 1'b0;
    next_cycle(); @(negedge clk);
    checks++;
    if ({a_ack1, a_err1, ram_we1, a_rdata1} !== {3'b110, 32'd0}) $display("FAIL size_word_misaligned ack/err/we/rdata got=%b %h want=110 0", {a_ack1, a_err1, ram_we1}, a_rdata1);
    else passes++;
    next_cycle();
    a_req = 1'b0;
  endtask

  task automatic test_misaligned();
    do_reset();
    a_req = 1'b1; a_we = 1'b1; a_half = 1'b1; a_addr = 32'h13; a_wdata = 32'h0000_1234;
    @(negedge clk);
    checks++;
    if (ram_we1 !== 1'b0) $display("FAIL mis_idle_we got=%b want=0", ram_we1);
    else passes++;
    next_cycle(); @(negedge clk);
    checks++;
    if ({a_ack1, a_err1, ram_we1, a_rdata1} !== {3'b110, 32'd0}) $display("FAIL mis_done ack/err/we/rdata got=%b %h want=110 0", {a_ack1, a_err1, ram_we1}, a_rdata1);
    else passes++;
    next_cycle();
    a_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_ack1, a_err1, ram_we1} !== 3'b000) $display("FAIL mis_after ack/err/we got=%b want=000", {a_ack1, a_err1, ram_we1});
    else passes++;
    checks++;
    if (mem1[4] !== 32'hDEAD_BEEF) $display("FAIL mis_ram_unchanged got=%h want=deadbeef", mem1[4]);
    else passes++;
  endtask

  task automatic test_arbitration();
    logic [1:0]  exp_ack;
    logic [31:0] exp_a, exp_b;
    do_reset();
    a_req = 1'b1; a_addr = 32'h10;
    b_req = 1'b1; b_addr = 32'h20;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (cyc % 2 == 0) exp_ack = 2'b00;
`ifdef MEM_ARB_FIXED_PRIO_EN
      else exp_ack = 2'b10;
`else
      else if (cyc == 3) exp_ack = 2'b01;
      else exp_ack = 2'b10;
`endif
      exp_a = exp_ack[1] ? 32'hDEAD_BEEF : 32'd0;
      exp_b = exp_ack[0] ? 32'hA000_0008 : 32'd0;
      @(negedge clk);
      checks++;
      if ({a_ack1, b_ack1, a_stall1} !== {exp_ack, ~exp_ack[1]}) $display("FAIL arb_ack cyc=%0d a/b/stall got=%b want=%b", cyc, {a_ack1, b_ack1, a_stall1}, {exp_ack, ~exp_ack[1]});
      else passes++;
      checks++;
      if ({a_rdata1, b_rdata1, a_err1, b_err1} !== {exp_a, exp_b, 2'b00}) $display("FAIL arb_data cyc=%0d a=%h b=%h err=%b want a=%h b=%h err=00", cyc, a_rdata1, b_rdata1, {a_err1, b_err1}, exp_a, exp_b);
      else passes++;
      next_cycle();
    end
    a_req = 1'b0; b_req = 1'b0;
  endtask

  task automatic test_latency3();
    logic exp_aack, exp_back, exp_stall;
    do_reset();
    b_req = 1'b1; b_addr = 32'h24;
    a_addr = 32'h08;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (cyc == 1) a_req = 1'b1;
      if (cyc == 4) b_req = 1'b0;
      exp_back  = (cyc == 3);
      exp_aack  = (cyc == 7);
      exp_stall = (cyc >= 1) && (cyc <= 6);
      @(negedge clk);
      checks++;
      if ({b_ack3, a_ack3, a_stall3} !== {exp_back, exp_aack, exp_stall}) $display("FAIL lat3 cyc=%0d b_ack/a_ack/stall got=%b want=%b", cyc, {b_ack3, a_ack3, a_stall3}, {exp_back, exp_aack, exp_stall});
      else passes++;
      if (cyc == 3 || cyc == 7) begin
        checks++;
        if ({b_rdata3, a_rdata3} !== {(exp_back ? 32'hA000_0009 : 32'd0), (exp_aack ? 32'hA000_0002 : 32'd0)}) $display("FAIL lat3_rdata cyc=%0d b=%h a=%h", cyc, b_rdata3, a_rdata3);
        else passes++;
      end
      next_cycle();
    end
    a_req = 1'b0;
  endtask

  task automatic test_clr_abort();
    do_reset();
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'h30; a_wdata = 32'h55AA_55AA;
    next_cycle(); @(negedge clk);
    checks++;
    if ({a_ack3, ram_we3, ram_addr3} !== {2'b00, 32'h30}) $display("FAIL abort_busy1 ack/we/addr got=%b %b %h want=0 0 30", a_ack3, ram_we3, ram_addr3);
    else passes++;
    next_cycle();
    CLR = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_ack3, ram_we3} !== 2'b00) $display("FAIL abort_clr_cycle ack/we got=%b want=00", {a_ack3, ram_we3});
    else passes++;
    next_cycle();
    CLR = 1'b0; a_req = 1'b0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      checks++;
      if ({a_ack3, a_err3, ram_we3, ram_addr3, ram_din3} !== {3'b000, 32'd0, 32'd0}) $display("FAIL abort_after cyc=%0d ack/err/we=%b addr=%h din=%h want zeros", cyc, {a_ack3, a_err3, ram_we3}, ram_addr3, ram_din3);
      else passes++;
      next_cycle();
    end
    checks++;
    if (mem3[12] !== 32'hA000_000C) $display("FAIL abort_ram_unchanged got=%h want=a000000c", mem3[12]);
    else passes++;
  endtask

  initial begin
    init_mem = 1'b1;
    CLR = 1'b1;
    next_cycle();
    init_mem = 1'b0;
    test_reset();
    test_write_read();
    test_sizes();
    test_misaligned();
    test_arbitration();
    test_latency3();
    test_clr_abort();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
